// File: rtl/reserve_station_pkg.sv
// reserve_station_pkg: shared widths, entry layout and CDB operand snoop helper
package reserve_station_pkg;
  localparam int OPERATOR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;
  localparam int ADDRESS_WIDTH = 32;
  localparam int ROB_WIDTH = 4;
  localparam int DEF_RS_SIZE = 8;
  localparam int DEF_RS_IDX_WIDTH = $clog2(DEF_RS_SIZE);
  typedef logic [OPERATOR_WIDTH-1:0] op_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [ROB_WIDTH-1:0] rob_t;
  localparam op_t NOP = '0;
  localparam data_t ZERO_DATA = '0;
  localparam addr_t ZERO_ADDR = '0;
  typedef struct packed {
    logic rdy;
    data_t val;
    rob_t tag;
  } operand_t;
  typedef struct packed {
    logic busy;
    op_t op;
    addr_t pc;
    data_t imm;
    rob_t reorder;
    operand_t rs;
    operand_t rt;
  } entry_t;
  function automatic operand_t snoop(input operand_t o, input logic ae, input rob_t at, input data_t av,
                                     input logic le, input rob_t lt, input data_t lv);
    snoop = o;
    if (!o.rdy && ae && o.tag == at) snoop = '{1'b1, av, o.tag};
    else if (!o.rdy && le && o.tag == lt) snoop = '{1'b1, lv, o.tag};
  endfunction
endpackage

// File: rtl/rs_priority_encoder.sv
// rs_priority_encoder: index of the lowest set request bit plus any-set flag
module rs_priority_encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/reserve_station.sv
// reserve_station: tag-matching reservation station feeding one ALU from two CDBs
module reserve_station
  import reserve_station_pkg::*;
#(
  parameter int RS_SIZE = DEF_RS_SIZE
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  input  logic  in_flush,
  input  logic  in_issue_enable,
  input  op_t   in_issue_type,
  input  addr_t in_issue_pc,
  input  data_t in_issue_imm,
  input  rob_t  in_issue_reorder,
  input  logic  in_issue_rs_ready,
  input  data_t in_issue_rs_value,
  input  rob_t  in_issue_rs_tag,
  input  logic  in_issue_rt_ready,
  input  data_t in_issue_rt_value,
  input  rob_t  in_issue_rt_tag,
  input  logic  in_alu_cdb_enable,
  input  rob_t  in_alu_cdb_reorder,
  input  data_t in_alu_cdb_result,
  input  logic  in_lsb_cdb_enable,
  input  rob_t  in_lsb_cdb_reorder,
  input  data_t in_lsb_cdb_result,
  output logic  out_full,
  output logic  out_alu_enable,
  output op_t   out_alu_type,
  output addr_t out_alu_pc,
  output data_t out_alu_imm,
  output data_t out_alu_rs,
  output data_t out_alu_rt,
  output rob_t  out_alu_reorder
);
  localparam int IDX_W = $clog2(RS_SIZE);
  entry_t ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy, ready;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic free_vld, sel_vld, disp;
  operand_t new_rs, new_rt;
  function automatic operand_t cap(input operand_t o);
    return snoop(o, in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
                 in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result);
  endfunction
  for (genvar g = 0; g < RS_SIZE; g++) begin : g_vec
    assign busy[g] = ent[g].busy;
    assign ready[g] = ent[g].busy & ent[g].rs.rdy & ent[g].rt.rdy;
  end
  assign out_full = &busy;
  assign disp = sel_vld & ~in_flush;
  assign new_rs = cap({in_issue_rs_ready, in_issue_rs_value, in_issue_rs_tag});
  assign new_rt = cap({in_issue_rt_ready, in_issue_rt_value, in_issue_rt_tag});
  rs_priority_encoder #(.N(RS_SIZE), .W(IDX_W)) u_free (.req(~busy), .idx(free_idx), .valid(free_vld));
  rs_priority_encoder #(.N(RS_SIZE), .W(IDX_W)) u_sel (.req(ready), .idx(sel_idx), .valid(sel_vld));
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      out_alu_enable <= 1'b0;
      out_alu_type <= NOP;
      out_alu_pc <= ZERO_ADDR;
      out_alu_imm <= ZERO_DATA;
      out_alu_rs <= ZERO_DATA;
      out_alu_rt <= ZERO_DATA;
      out_alu_reorder <= '0;
    end else if (rdy_in) begin
      out_alu_enable <= disp;
      out_alu_type <= disp ? ent[sel_idx].op : NOP;
      out_alu_pc <= disp ? ent[sel_idx].pc : ZERO_ADDR;
      out_alu_imm <= disp ? ent[sel_idx].imm : ZERO_DATA;
      out_alu_rs <= disp ? ent[sel_idx].rs.val : ZERO_DATA;
      out_alu_rt <= disp ? ent[sel_idx].rt.val : ZERO_DATA;
      out_alu_reorder <= disp ? ent[sel_idx].reorder : '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (in_flush) ent[i].busy <= 1'b0;
        else begin
          if (ent[i].busy) begin
            ent[i].rs <= cap(ent[i].rs);
            ent[i].rt <= cap(ent[i].rt);
          end
          // selected entry is busy, free entry is not, so these never collide
          if (sel_vld && IDX_W'(i) == sel_idx) ent[i].busy <= 1'b0;
          if (in_issue_enable && free_vld && IDX_W'(i) == free_idx)
            ent[i] <= '{1'b1, in_issue_type, in_issue_pc, in_issue_imm, in_issue_reorder, new_rs, new_rt};
        end
      end
    end
  end
endmodule

// File: tb/tb_reserve_station.sv
// tb_reserve_station: directed plus random stimulus scored against a behavioural model
module tb_reserve_station;
  import reserve_station_pkg::*;
  localparam int N = 8;
  typedef struct packed {
    logic full;
    logic en;
    op_t op;
    addr_t pc;
    data_t imm;
    data_t rs;
    data_t rt;
    rob_t reorder;
  } out_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_in, rdy_in, in_flush, in_issue_enable, in_issue_rs_ready, in_issue_rt_ready;
  op_t in_issue_type;
  addr_t in_issue_pc;
  data_t in_issue_imm, in_issue_rs_value, in_issue_rt_value, in_alu_cdb_result, in_lsb_cdb_result;
  rob_t in_issue_reorder, in_issue_rs_tag, in_issue_rt_tag, in_alu_cdb_reorder, in_lsb_cdb_reorder;
  logic in_alu_cdb_enable, in_lsb_cdb_enable;
  logic out_full, out_alu_enable;
  op_t out_alu_type;
  addr_t out_alu_pc;
  data_t out_alu_imm, out_alu_rs, out_alu_rt;
  rob_t out_alu_reorder;
  reserve_station #(.RS_SIZE(N)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .in_flush(in_flush),
    .in_issue_enable(in_issue_enable), .in_issue_type(in_issue_type), .in_issue_pc(in_issue_pc),
    .in_issue_imm(in_issue_imm), .in_issue_reorder(in_issue_reorder),
    .in_issue_rs_ready(in_issue_rs_ready), .in_issue_rs_value(in_issue_rs_value), .in_issue_rs_tag(in_issue_rs_tag),
    .in_issue_rt_ready(in_issue_rt_ready), .in_issue_rt_value(in_issue_rt_value), .in_issue_rt_tag(in_issue_rt_tag),
    .in_alu_cdb_enable(in_alu_cdb_enable), .in_alu_cdb_reorder(in_alu_cdb_reorder), .in_alu_cdb_result(in_alu_cdb_result),
    .in_lsb_cdb_enable(in_lsb_cdb_enable), .in_lsb_cdb_reorder(in_lsb_cdb_reorder), .in_lsb_cdb_result(in_lsb_cdb_result),
    .out_full(out_full), .out_alu_enable(out_alu_enable), .out_alu_type(out_alu_type), .out_alu_pc(out_alu_pc),
    .out_alu_imm(out_alu_imm), .out_alu_rs(out_alu_rs), .out_alu_rt(out_alu_rt), .out_alu_reorder(out_alu_reorder)
  );
  out_t exp_q[$];
  out_t last_out, act, expv;
  int vectors = 0, miscompares = 0;
  bit started = 0;
  bit m_busy[N];
  op_t m_op[N];
  addr_t m_pc[N];
  data_t m_imm[N];
  rob_t m_rob[N];
  bit m_rdy[N][2];
  data_t m_val[N][2];
  rob_t m_tag[N][2];

  function automatic out_t idle();
    return '{full: 1'b0, en: 1'b0, op: NOP, pc: ZERO_ADDR, imm: ZERO_DATA, rs: ZERO_DATA, rt: ZERO_DATA, reorder: '0};
  endfunction

  // a waiting operand takes the ALU broadcast if it matches, else the LSB one
  task automatic resolve(input bit r, input data_t v, input rob_t t, output bit ro, output data_t vo);
    ro = r;
    vo = v;
    if (!r && in_alu_cdb_enable && t == in_alu_cdb_reorder) begin ro = 1; vo = in_alu_cdb_result; end
    else if (!r && in_lsb_cdb_enable && t == in_lsb_cdb_reorder) begin ro = 1; vo = in_lsb_cdb_result; end
  endtask

  task automatic model_step();
    out_t o;
    int d, f, nb;
    o = idle();
    if (rst_in) begin
      foreach (m_busy[i]) m_busy[i] = 0;
    end else if (!rdy_in) begin
      o = last_out;
    end else if (in_flush) begin
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      d = -1;
      f = -1;
      for (int i = 0; i < N; i++) begin
        if (d < 0 && m_busy[i] && m_rdy[i][0] && m_rdy[i][1]) d = i;
        if (f < 0 && !m_busy[i]) f = i;
      end
      if (d >= 0) begin
        o.en = 1;
        o.op = m_op[d];
        o.pc = m_pc[d];
        o.imm = m_imm[d];
        o.rs = m_val[d][0];
        o.rt = m_val[d][1];
        o.reorder = m_rob[d];
      end
      for (int i = 0; i < N; i++)
        if (m_busy[i])
          for (int k = 0; k < 2; k++) begin
            bit r;
            data_t v;
            resolve(m_rdy[i][k], m_val[i][k], m_tag[i][k], r, v);
            m_rdy[i][k] = r;
            m_val[i][k] = v;
          end
      if (d >= 0) m_busy[d] = 0;
      if (in_issue_enable && f >= 0) begin
        bit r;
        data_t v;
        m_busy[f] = 1;
        m_op[f] = in_issue_type;
        m_pc[f] = in_issue_pc;
        m_imm[f] = in_issue_imm;
        m_rob[f] = in_issue_reorder;
        m_tag[f][0] = in_issue_rs_tag;
        m_tag[f][1] = in_issue_rt_tag;
        resolve(in_issue_rs_ready, in_issue_rs_value, in_issue_rs_tag, r, v);
        m_rdy[f][0] = r;
        m_val[f][0] = v;
        resolve(in_issue_rt_ready, in_issue_rt_value, in_issue_rt_tag, r, v);
        m_rdy[f][1] = r;
        m_val[f][1] = v;
      end
    end
    nb = 0;
    foreach (m_busy[i]) nb += int'(m_busy[i]);
    o.full = (nb == N);
    last_out = o;
    exp_q.push_back(o);
  endtask

  always @(negedge clk) begin
    if (started) begin
      act = '{full: out_full, en: out_alu_enable, op: out_alu_type, pc: out_alu_pc, imm: out_alu_imm,
              rs: out_alu_rs, rt: out_alu_rt, reorder: out_alu_reorder};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL outputs: actual=%h, nothing expected", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          miscompares++;
          $display("FAIL outputs t=%0t: actual=%h required=%h", $time, act, expv);
        end
      end
    end
  end

  task automatic tick();
    model_step();
    started = 1;
    @(negedge clk);
    #1;
    in_issue_enable = 0;
    in_alu_cdb_enable = 0;
    in_lsb_cdb_enable = 0;
    in_flush = 0;
  endtask

  task automatic issue(input op_t op, input addr_t pc, input data_t imm, input rob_t rob,
                       input bit rsr, input data_t rsv, input rob_t rst, input bit rtr, input data_t rtv, input rob_t rtt);
    in_issue_enable = 1;
    in_issue_type = op;
    in_issue_pc = pc;
    in_issue_imm = imm;
    in_issue_reorder = rob;
    in_issue_rs_ready = rsr;
    in_issue_rs_value = rsv;
    in_issue_rs_tag = rst;
    in_issue_rt_ready = rtr;
    in_issue_rt_value = rtv;
    in_issue_rt_tag = rtt;
  endtask

  task automatic alu(input rob_t t, input data_t v);
    in_alu_cdb_enable = 1; in_alu_cdb_reorder = t; in_alu_cdb_result = v;
  endtask

  task automatic lsb(input rob_t t, input data_t v);
    in_lsb_cdb_enable = 1; in_lsb_cdb_reorder = t; in_lsb_cdb_result = v;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; in_flush = 0;
    in_alu_cdb_enable = 0; in_alu_cdb_reorder = '0; in_alu_cdb_result = '0;
    in_lsb_cdb_enable = 0; in_lsb_cdb_reorder = '0; in_lsb_cdb_result = '0;
    issue(NOP, '0, '0, '0, 0, '0, '0, 0, '0, '0);
    in_issue_enable = 0;
    idle_ticks(2);
    rst_in = 0;
    issue(6'd1, 32'h100, 32'd3, 4'd2, 1, 32'd5, '0, 1, 32'd0, '0);
    idle_ticks(3);
    issue(6'd2, 32'h104, 32'd0, 4'd3, 0, 32'd0, 4'd4, 1, 32'd7, '0);
    idle_ticks(2);
    alu(4'd4, 32'd10);
    idle_ticks(3);
    issue(6'd3, 32'h108, 32'd1, 4'd5, 0, 32'd0, 4'd6, 1, 32'd9, '0);
    lsb(4'd6, 32'h1234);
    idle_ticks(3);
    for (int i = 0; i < 9; i++) begin
      issue(6'd4, 32'h200 + 32'(i), 32'(i), 4'(i + 8), 0, 32'd0, 4'd1, 1, 32'(i * 3), '0);
      tick();
    end
    alu(4'd1, 32'hABCD);
    idle_ticks(10);
    for (int i = 0; i < 3; i++) begin
      issue(6'd5, 32'h300, 32'(i), 4'(i), 0, '0, 4'd3, 0, '0, 4'd3);
      tick();
    end
    in_flush = 1;
    tick();
    alu(4'd3, 32'd77);
    idle_ticks(3);
    issue(6'd6, 32'h400, 32'd2, 4'd9, 1, 32'd11, '0, 1, 32'd12, '0);
    tick();
    issue(6'd7, 32'h404, 32'd0, 4'd10, 0, '0, 4'd5, 1, 32'd1, '0);
    tick();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      alu(4'd5, 32'd55);
      issue(6'd8, 32'h408, 32'd0, 4'd11, 1, 32'd1, '0, 1, 32'd2, '0);
      in_flush = (i == 1);
      tick();
    end
    rdy_in = 1;
    alu(4'd5, 32'd56);
    idle_ticks(4);
    issue(6'd9, 32'h500, 32'd0, 4'd1, 0, '0, 4'd2, 1, '0, '0);
    tick();
    rst_in = 1;
    tick();
    rst_in = 0;
    issue(6'd10, 32'h504, 32'd4, 4'd3, 1, 32'd8, '0, 1, 32'd9, '0);
    idle_ticks(3);
    for (int c = 0; c < 600; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      rst_in = ($urandom_range(0, 149) == 0);
      in_flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1)
        issue(op_t'($urandom), addr_t'($urandom), data_t'($urandom), rob_t'($urandom),
              bit'($urandom_range(0, 1)), data_t'($urandom), rob_t'($urandom_range(0, 7)),
              bit'($urandom_range(0, 1)), data_t'($urandom), rob_t'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) alu(rob_t'($urandom_range(0, 7)), data_t'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        lsb(rob_t'($urandom_range(0, 7)), data_t'($urandom));
        if (in_alu_cdb_enable && in_lsb_cdb_reorder == in_alu_cdb_reorder) in_lsb_cdb_reorder ^= 4'd8;
      end
      tick();
    end
    rst_in = 0;
    rdy_in = 1;
    idle_ticks(12);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reserve_station.md
RESERVE_STATION -- requirements
Module: reserve_station

Interface
REQ-001 Parameter: RS_SIZE, 8, number of entries (power of two, 2..16).
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global ready; low freezes all registers.
REQ-005 in_flush  input  1  misprediction clear from ROB.
REQ-006 in_issue_enable  input  1  new instruction from dispatcher.
REQ-007 in_issue_type/pc/imm/reorder  input  OPERATOR/ADDRESS/DATA/ROB widths  opcode, pc, immediate, destination ROB tag.
REQ-008 in_issue_rs_ready, in_issue_rt_ready  input  1 each  operand value valid.
REQ-009 in_issue_rs_value/rt_value  input  DATA  operand values; in_issue_rs_tag/rt_tag  input  ROB  producer tags when not ready.
REQ-010 in_alu_cdb_enable/reorder/result  input  1/ROB/DATA  ALU broadcast.
REQ-011 in_lsb_cdb_enable/reorder/result  input  1/ROB/DATA  load-store broadcast.
REQ-012 out_full  output  1  no free entry.
REQ-013 out_alu_enable/type/pc/imm/rs/rt/reorder  output  1/OPERATOR/ADDRESS/DATA/DATA/DATA/ROB  registered ALU operands.

Function
REQ-014 Entry state: busy, type, pc, imm, reorder, per operand {ready, value, tag}.
REQ-015 out_full SHALL equal AND of all busy bits, derived combinationally from registers.
REQ-016 Issue when in_issue_enable & !out_full: write lowest-index non-busy entry, set busy; issue while full is ignored.
REQ-017 Issue-time bypass: a not-ready operand whose tag matches an enabled CDB that same cycle SHALL be stored ready with the CDB result.
REQ-018 Capture: every busy entry operand not ready whose tag matches in_alu_cdb_reorder (alu enable) or in_lsb_cdb_reorder (lsb enable) SHALL become ready with that result at the edge; both buses may match different entries/operands the same cycle.
REQ-019 Select: each edge, lowest-index busy entry with both operands ready (at cycle start) is dispatched: its fields load out_alu_*, out_alu_enable=1, busy cleared.
REQ-020 No ready entry: out_alu_enable=0, type=`NOP, data outputs `ZERO_DATA/`ZERO_ADDR.
REQ-021 Latency: issue with both operands ready at edge E0 -> out_alu_enable high after E1; operand captured at edge E -> dispatch no earlier than E+1.
REQ-022 At most one issue and one dispatch per cycle; issue into an entry freed by dispatch in the same cycle is not permitted (freed slot usable next cycle).
REQ-023 in_flush (rdy_in high): at the edge all busy cleared, out_alu_enable=0; flush outranks issue, capture and dispatch.
REQ-024 rdy_in low: all registers hold, including outputs; issue, CDB and flush are ignored.
REQ-025 Tag compare is full ROB width; value fields never altered except by issue or capture.

Reset
REQ-026 rst_in high asynchronously clears all busy/ready bits, out_alu_enable=0, out_alu_type=`NOP, other outputs zero; out_full=0.
REQ-027 Reset mid-operation discards all entries; first issue after release is accepted at the next edge.

Structure
REQ-028 def.v holds OPERATOR_WIDTH, DATA_WIDTH, ADDRESS_WIDTH, ROB_WIDTH, `NOP, ZERO_DATA, ZERO_ADDR and new RS_SIZE/RS_IDX_WIDTH.
REQ-029 One sub-module rs_priority_encoder (lowest set bit -> index + valid), instantiated twice: free-slot and ready-slot selection.

Verification
REQ-030 Reset, issue ADDI rs=5 imm=3 reorder=2 ready -> one cycle later out_alu_enable=1, rs=5, imm=3, reorder=2; next cycle enable=0.
REQ-031 Issue ADD rs tag=4 not ready, rt=7 -> no dispatch; ALU CDB reorder=4 result=10 -> dispatch next edge with rs=10, rt=7.
REQ-032 Issue with rs tag=6 while LSB CDB broadcasts reorder=6 result=0x1234 same cycle -> dispatched next edge with rs=0x1234.
REQ-033 Fill 8 entries waiting on tag 1 -> out_full=1, ninth issue dropped; CDB tag 1 -> entries dispatch index 0..7 on 8 consecutive edges, out_full falls after first.
REQ-034 Three busy entries, assert in_flush -> next cycle out_alu_enable=0, out_full=0, later CDB matches dispatch nothing.
REQ-035 rdy_in low for 3 cycles with ready entry and CDB traffic -> outputs frozen, no dispatch; resumes on rdy_in high.
